usb3_line_sequencer: RTL and testbench

- Read-side controller for the USB3 buffering FIFO, running in the FPGA clock domain.
- Waits until a full display line is buffered and the downstream line buffer is free, then bursts exactly WORDS_PER_LINE reads out of the FIFO and writes them into the line buffer at sequential addresses.
- Tracks line and frame position and flags FIFO underruns.
- Sits between the USB3 interface read port and the SLM line-buffer write port.

---
 rtl/usb3_line_sequencer.sv | 121 ++++++++++++
 tb/tb_usb3_line_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_line_sequencer.sv
// Read-side sequencer for the USB3 FIFO: bursts one display line at a time
// into the SLM line buffer, tracking line/frame position and FIFO underruns.
module usb3_line_sequencer #(
  parameter int WORDS_PER_LINE  = 40,
  parameter int LINES_PER_FRAME = 1280,
  parameter int ADDR_W          = 6,
  parameter int LINE_W          = 11
) (
  input  logic              fpga_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_dataline_available,
  output logic              get_next_word,
  input  logic [31:0]       fifo_data_out,
  input  logic              buf_free,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic              line_done,
  output logic [LINE_W-1:0] line_index,
  output logic              frame_done,
  output logic              underrun_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    LDONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] idx_d;
  logic              gnw_d, wr_en_d, done_d, frame_d, err_d, busy_d;
  logic              start, take;

  assign start = enable & fifo_dataline_available & buf_free;
  assign take  = ~fifo_empty;

  // FIFO data is valid in the cycle after the read, which is the write
  // cycle; gating keeps the data bus at zero whenever no write is strobed.
  assign buf_wr_data = buf_wr_en ? fifo_data_out : 32'd0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnw_d   = 1'b0;
    wr_en_d = get_next_word;
    addr_d  = buf_wr_en ? buf_wr_addr + 1'b1 : buf_wr_addr;
    done_d  = 1'b0;
    frame_d = 1'b0;
    idx_d   = line_index;
    err_d   = underrun_err;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = READ;
          gnw_d   = take;
          cnt_d   = CNT_W'(take);
        end
      end
      READ: begin
        if (cnt == LAST_CNT) begin
          state_d = DRAIN;
        end else begin
          gnw_d = take;
          cnt_d = cnt + CNT_W'(take);
          if (fifo_empty) err_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = LDONE;
        done_d  = 1'b1;
        frame_d = (line_index == LAST_LINE);
      end
      LDONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        addr_d  = '0;
        idx_d   = (line_index == LAST_LINE) ? '0 : line_index + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      get_next_word <= 1'b0;
      buf_wr_en     <= 1'b0;
      buf_wr_addr   <= '0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      line_index    <= '0;
      underrun_err  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      get_next_word <= gnw_d;
      buf_wr_en     <= wr_en_d;
      buf_wr_addr   <= addr_d;
      line_done     <= done_d;
      frame_done    <= frame_d;
      line_index    <= idx_d;
      underrun_err  <= err_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_usb3_line_sequencer.sv
// Bench for usb3_line_sequencer: FIFO model, write monitor, vector table
// and directed stall / enable / reset sequences.
module tb_usb3_line_sequencer;

  localparam int WPL = 40;
  localparam int LPF = 4;

  logic        fpga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        buf_free = 1'b0;
  logic        force_empty = 1'b0;
  logic        fifo_empty, fifo_dataline_available;
  logic        get_next_word, buf_wr_en, line_done, frame_done;
  logic        underrun_err, busy;
  logic [31:0] fifo_data_out = 32'd0;
  logic [31:0] buf_wr_data;
  logic [5:0]  buf_wr_addr;
  logic [10:0] line_index;

  logic [31:0] mem [256];
  logic [31:0] wr_ptr = 32'd0;
  logic [31:0] rd_ptr = 32'd0;

  int total = 0;
  int bad = 0;

  always #5 fpga_clk = ~fpga_clk;

  assign fifo_empty = (wr_ptr == rd_ptr) | force_empty;
  assign fifo_dataline_available = (wr_ptr - rd_ptr) >= 32'd40;

  usb3_line_sequencer #(
    .WORDS_PER_LINE(WPL),
    .LINES_PER_FRAME(LPF),
    .ADDR_W(6),
    .LINE_W(11)
  ) dut (
    .fpga_clk(fpga_clk),
    .reset_n(reset_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_dataline_available(fifo_dataline_available),
    .get_next_word(get_next_word),
    .fifo_data_out(fifo_data_out),
    .buf_free(buf_free),
    .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .line_done(line_done),
    .line_index(line_index),
    .frame_done(frame_done),
    .underrun_err(underrun_err),
    .busy(busy)
  );

  // Standard FIFO: data for a read appears the cycle after get_next_word.
  always @(posedge fpga_clk) begin
    if (get_next_word) begin
      fifo_data_out <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 32'd1;
    end
  end

  int cyc = 0;
  int rd_cnt = 0;
  int ld_cnt = 0;
  int fd_cnt = 0;
  int orphan = 0;
  int rd_cyc[$];
  int wr_cyc[$];
  int ld_cyc[$];
  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge fpga_clk) begin
    cyc <= cyc + 1;
    if (get_next_word) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc.push_back(cyc);
    end
    if (buf_wr_en) begin
      wa.push_back(buf_wr_addr);
      wd.push_back(buf_wr_data);
      wr_cyc.push_back(cyc);
    end
    if (line_done) begin
      ld_cnt <= ld_cnt + 1;
      ld_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (!line_done) orphan <= orphan + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fpga_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = base + 32'(i);
      wr_ptr = wr_ptr + 32'd1;
    end
  endtask

  task automatic wait_rd(input int target, input string nm);
    int b = 300;
    while (rd_cnt < target && b > 0) begin
      tick(1);
      b--;
    end
    check(nm, 64'(rd_cnt >= target), 64'd1);
  endtask

  task automatic wait_ld(input int target, input string nm);
    int b = 300;
    while (ld_cnt < target && b > 0) begin
      tick(1);
      b--;
    end
    check(nm, 64'(ld_cnt >= target), 64'd1);
  endtask

  task automatic check_line(input string nm, input int w0,
                            input logic [31:0] base);
    check({nm, "_nwrites"}, 64'(wa.size() - w0), 64'd40);
    for (int i = 0; i < WPL; i++) begin
      if (w0 + i < wa.size())
        check({nm, "_word"}, {26'd0, wa[w0+i], wd[w0+i]},
              {26'd0, 6'(i), base + 32'(i)});
    end
  endtask

  typedef struct {
    logic en;
    logic free;
    int   push;
    int   cycles;
    int   exp_reads;
    int   exp_lines;
    int   exp_frames;
    int   exp_idx;
    logic exp_busy;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, w0, l0, f0, w1, l1, nextw;
    logic [31:0] base;

    vt[0] = '{1'b1, 1'b0, 40, 20, 0, 0, 0, 1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 0, 1, 1, 0, 0, 1, 1'b1};
    vt[2] = '{1'b1, 1'b1, 0, 60, 39, 1, 0, 2, 1'b0};
    vt[3] = '{1'b1, 1'b1, 80, 100, 80, 2, 1, 0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 40, 20, 0, 0, 0, 0, 1'b0};

    tick(3);
    check("rst_gnw", 64'(get_next_word), 64'd0);
    check("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_done", 64'({line_done, frame_done}), 64'd0);
    check("rst_err", 64'(underrun_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(buf_wr_addr), 64'd0);
    check("rst_data", 64'(buf_wr_data), 64'd0);
    check("rst_idx", 64'(line_index), 64'd0);
    reset_n = 1'b1;
    tick(1);

    r0 = rd_cnt; w0 = wa.size(); l0 = ld_cnt;
    enable = 1'b1;
    buf_free = 1'b1;
    push(40, 32'd0);
    nextw = 40;
    wait_ld(l0 + 1, "t1_wait_ld");
    tick(2);
    check("t1_reads", 64'(rd_cnt - r0), 64'd40);
    check("t1_read_span",
          64'((rd_cyc.size() > r0 + 39) ? rd_cyc[r0+39] - rd_cyc[r0] : -1),
          64'd39);
    check_line("t1", w0, 32'd0);
    check("t1_ld_after_last_wr",
          64'((wr_cyc.size() > w0 + 39 && ld_cyc.size() > l0) ?
              ld_cyc[l0] - wr_cyc[w0+39] : -1), 64'd1);
    check("t1_idx", 64'(line_index), 64'd1);
    check("t1_err", 64'(underrun_err), 64'd0);
    check("t1_frames", 64'(fd_cnt), 64'd0);

    for (int i = 0; i < 5; i++) begin
      r0 = rd_cnt; l0 = ld_cnt; f0 = fd_cnt;
      enable = vt[i].en;
      buf_free = vt[i].free;
      push(vt[i].push, 32'(nextw));
      nextw += vt[i].push;
      tick(vt[i].cycles);
      check($sformatf("v%0d_reads", i), 64'(rd_cnt - r0), 64'(vt[i].exp_reads));
      check($sformatf("v%0d_lines", i), 64'(ld_cnt - l0), 64'(vt[i].exp_lines));
      check($sformatf("v%0d_frames", i), 64'(fd_cnt - f0),
            64'(vt[i].exp_frames));
      check($sformatf("v%0d_idx", i), 64'(line_index), 64'(vt[i].exp_idx));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
    end
    check("b2b_period",
          64'((ld_cyc.size() >= 2) ?
              ld_cyc[ld_cyc.size()-1] - ld_cyc[ld_cyc.size()-2] : -1),
          64'd43);
    check("frame_orphan", 64'(orphan), 64'd0);

    base = 32'(nextw - 40);
    r0 = rd_cnt; w0 = wa.size(); l0 = ld_cnt;
    enable = 1'b1;
    wait_rd(r0 + 10, "st_wait_rd");
    force_empty = 1'b1;
    tick(3);
    force_empty = 1'b0;
    wait_ld(l0 + 1, "st_wait_ld");
    tick(2);
    check("st_gap",
          64'((rd_cyc.size() > r0 + 10) ? rd_cyc[r0+10] - rd_cyc[r0+9] : -1),
          64'd4);
    check("st_span",
          64'((rd_cyc.size() > r0 + 39) ? rd_cyc[r0+39] - rd_cyc[r0] : -1),
          64'd42);
    check_line("st", w0, base);
    check("st_err", 64'(underrun_err), 64'd1);
    check("st_idx", 64'(line_index), 64'd1);
    tick(10);
    check("st_err_sticky", 64'(underrun_err), 64'd1);
    check("st_one_ld", 64'(ld_cnt - l0), 64'd1);

    base = 32'h200;
    r0 = rd_cnt; w0 = wa.size(); l0 = ld_cnt;
    push(80, base);
    wait_rd(r0 + 5, "en_wait_rd");
    enable = 1'b0;
    wait_ld(l0 + 1, "en_wait_ld");
    tick(20);
    check("en_reads", 64'(rd_cnt - r0), 64'd40);
    check_line("en", w0, base);
    check("en_lines", 64'(ld_cnt - l0), 64'd1);
    check("en_busy", 64'(busy), 64'd0);
    check("en_idx", 64'(line_index), 64'd2);

    r0 = rd_cnt; w0 = wa.size(); l0 = ld_cnt;
    enable = 1'b1;
    wait_rd(r0 + 20, "rs_wait_rd");
    reset_n = 1'b0;
    tick(1);
    check("rs_gnw", 64'(get_next_word), 64'd0);
    check("rs_wr_en", 64'(buf_wr_en), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_idx", 64'(line_index), 64'd0);
    check("rs_addr", 64'(buf_wr_addr), 64'd0);
    check("rs_data", 64'(buf_wr_data), 64'd0);
    check("rs_err", 64'(underrun_err), 64'd0);
    tick(3);
    check("rs_writes", 64'(wa.size() - w0), 64'd19);
    check("rs_reads", 64'(rd_cnt - r0), 64'd20);
    check("rs_no_ld", 64'(ld_cnt - l0), 64'd0);
    wr_ptr = rd_ptr;
    reset_n = 1'b1;
    tick(1);
    w1 = wa.size(); l1 = ld_cnt;
    push(40, 32'h300);
    wait_ld(l1 + 1, "rs_wait_ld");
    tick(2);
    check_line("rs_line", w1, 32'h300);
    check("rs_line_idx", 64'(line_index), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
